// File: rtl/bb2sram_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bb2sram_pkg
// Description : Shared types and address helpers for the Blackbone-to-SRAM
//               burst bridge (FSM state encoding, wrap-burst stepping).
// Revision    : 1.0 - initial release
// ============================================================================
package bb2sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } bb2sram_state_t;

  // Helpers work on a fixed wide vector; callers zero-extend and truncate.
  localparam int C_FN_W = 64;

  function automatic logic is_pow2(input logic [C_FN_W-1:0] n);
    return (n != '0) && ((n & (n - 64'd1)) == '0);
  endfunction

  // For a power-of-two block of N = len+1 words, len is also the in-block
  // mask: the low bits step modulo N while the upper bits stay put.
  function automatic logic [C_FN_W-1:0] wrap_next(input logic [C_FN_W-1:0] addr,
                                                  input logic [C_FN_W-1:0] len);
    return (addr & ~len) | ((addr + 64'd1) & len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bb2sram_burst_if.sv
`default_nettype none
// ============================================================================
// Interface   : bb2sram_burst_if
// Description : Blackbone request/response bundle between a bus master and
//               the SRAM burst bridge.
//   master : drives en/we/addr/sel/len/wrap/din, observes busy/dout/rvalid/rlast
//   slave  : the bridge side of the same signals
// Revision    : 1.0 - initial release
// ============================================================================
interface bb2sram_burst_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int LW = 4
);
  localparam int SW = DW / 8;

  logic          bb_en_i;
  logic          bb_we_i;
  logic [AW-1:0] bb_addr_i;
  logic [SW-1:0] bb_sel_i;
  logic [LW-1:0] bb_len_i;
  logic          bb_wrap_i;
  logic [DW-1:0] bb_din_i;
  logic          bb_busy_o;
  logic [DW-1:0] bb_dout_o;
  logic          bb_rvalid_o;
  logic          bb_rlast_o;

  modport master (
    output bb_en_i, bb_we_i, bb_addr_i, bb_sel_i, bb_len_i, bb_wrap_i, bb_din_i,
    input  bb_busy_o, bb_dout_o, bb_rvalid_o, bb_rlast_o
  );

  modport slave (
    input  bb_en_i, bb_we_i, bb_addr_i, bb_sel_i, bb_len_i, bb_wrap_i, bb_din_i,
    output bb_busy_o, bb_dout_o, bb_rvalid_o, bb_rlast_o
  );

endinterface
`default_nettype wire

// File: rtl/bb2sram_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : bb2sram_addr_gen
// Description : Burst word-address generator. Loads the start address on
//               i_start (that beat is issued directly by the caller, so the
//               register holds the *next* address), steps once per i_step
//               with linear or wrap increment, and counts issued beats.
// Ports       : clk, rst          clock, async active-high reset
//               i_start           accept cycle: load from i_start_addr/i_len/i_wrap
//               i_step            a beat at o_addr is being issued this cycle
//               o_addr            word address of the beat to issue next
//               o_last            the beat at o_addr is beat number len
// Revision    : 1.0 - initial release
// ============================================================================
module bb2sram_addr_gen
  import bb2sram_pkg::*;
#(
  parameter int WORD_AW = 30,
  parameter int LW      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_step,
  input  logic [WORD_AW-1:0] i_start_addr,
  input  logic [LW-1:0]      i_len,
  input  logic               i_wrap,
  output logic [WORD_AW-1:0] o_addr,
  output logic               o_last
);

  logic [WORD_AW-1:0] r_addr;
  logic [LW:0]        r_cnt;   // one extra bit so 2**LW beats cannot overflow
  logic [LW-1:0]      r_len;
  logic               r_wrap;  // wrap requested and block size is a power of 2

  logic [C_FN_W-1:0]  w_base64;
  logic [C_FN_W-1:0]  w_len64;
  logic [C_FN_W-1:0]  w_next64;
  logic               w_wrap_sel;
  logic               w_unused_next;

  // One next-address computation shared by the load and step paths.
  always_comb begin
    w_base64 = '0;
    w_len64  = '0;
    w_base64[WORD_AW-1:0] = i_start ? i_start_addr : r_addr;
    w_len64[LW-1:0]       = i_start ? i_len : r_len;
    // Non-power-of-two wrap requests fall back to linear stepping.
    w_wrap_sel = i_start ? (i_wrap && is_pow2(w_len64 + 64'd1)) : r_wrap;
    w_next64   = w_wrap_sel ? wrap_next(w_base64, w_len64) : (w_base64 + 64'd1);
  end

  // Truncation to WORD_AW bits gives the mod 2**WORD_AW linear rollover.
  assign w_unused_next = &{1'b0, w_next64};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_len  <= '0;
      r_wrap <= 1'b0;
    end else if (i_start) begin
      r_addr <= w_next64[WORD_AW-1:0];
      r_cnt  <= (LW+1)'(1);
      r_len  <= i_len;
      r_wrap <= w_wrap_sel;
    end else if (i_step) begin
      r_addr <= w_next64[WORD_AW-1:0];
      r_cnt  <= r_cnt + (LW+1)'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = ({1'b0, r_len} == r_cnt);

endmodule
`default_nettype wire

// File: rtl/bb2sram_burst.sv
`default_nettype none
// ============================================================================
// Module      : bb2sram_burst
// Description : Blackbone-to-single-port-SRAM bridge with byte lanes,
//               linear/wrap bursts of up to 2**LW beats and an RD_LAT-cycle
//               SRAM read latency. Beat 0 is issued combinationally in the
//               accept cycle; later beats come from bb2sram_addr_gen, one per
//               cycle. A shift register realigns read-valid/last to sram_dout.
// Ports       : bb_clk_i, bb_rst_i  clock, async active-high reset
//               bb                  Blackbone slave (request in, busy/read data out)
//               sram_ce/we/waddr/din/sel  SRAM command and write data
//               sram_dout           SRAM read data, RD_LAT cycles after address
// Revision    : 1.0 - initial release
// ============================================================================
module bb2sram_burst
  import bb2sram_pkg::*;
#(
  parameter  int DW      = 32,
  parameter  int AW      = 32,
  parameter  int LW      = 4,
  parameter  int RD_LAT  = 1,
  localparam int SW      = DW / 8,
  localparam int BYTE_AW = $clog2(SW),
  localparam int WORD_AW = AW - BYTE_AW
) (
  input  logic               bb_clk_i,
  input  logic               bb_rst_i,
  bb2sram_burst_if.slave     bb,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [DW-1:0]      sram_dout
);

  bb2sram_state_t      r_state;
  logic                r_busy;
  logic                r_we;
  logic [SW-1:0]       r_sel;
  logic [WORD_AW-1:0]  r_hold_addr;   // keeps sram_waddr quiet between bursts
  logic [RD_LAT-1:0]   r_vpipe;
  logic [RD_LAT-1:0]   r_lpipe;

  logic                w_accept;
  logic                w_burst;
  logic                w_issue_last;
  logic                w_rd_issue;
  logic [WORD_AW-1:0]  w_gen_addr;
  logic                w_gen_last;
  logic                w_unused_addr;

  bb2sram_addr_gen #(
    .WORD_AW (WORD_AW),
    .LW      (LW)
  ) u_addr_gen (
    .clk          (bb_clk_i),
    .rst          (bb_rst_i),
    .i_start      (w_accept),
    .i_step       (w_burst),
    .i_start_addr (bb.bb_addr_i[AW-1:BYTE_AW]),
    .i_len        (bb.bb_len_i),
    .i_wrap       (bb.bb_wrap_i),
    .o_addr       (w_gen_addr),
    .o_last       (w_gen_last)
  );

  // Byte-offset bits of the request address carry no meaning here.
  assign w_unused_addr = &{1'b0, bb.bb_addr_i};

  // Reset also blocks acceptance so the SRAM sees no access while it is held.
  always_comb begin
    w_accept = (r_state == ST_IDLE) && bb.bb_en_i && !bb_rst_i;
    w_burst  = (r_state == ST_BURST);
    sram_ce  = w_accept || w_burst;
    if (w_accept) begin
      sram_we      = bb.bb_we_i;
      sram_waddr   = bb.bb_addr_i[AW-1:BYTE_AW];
      sram_sel     = bb.bb_we_i ? bb.bb_sel_i : '1;
      w_issue_last = (bb.bb_len_i == '0);
    end else if (w_burst) begin
      sram_we      = r_we;
      sram_waddr   = w_gen_addr;
      sram_sel     = r_we ? r_sel : '1;
      w_issue_last = w_gen_last;
    end else begin
      sram_we      = 1'b0;
      sram_waddr   = r_hold_addr;
      sram_sel     = r_we ? r_sel : '1;
      w_issue_last = 1'b0;
    end
    w_rd_issue = sram_ce && !sram_we;
  end

  always_ff @(posedge bb_clk_i or posedge bb_rst_i) begin
    if (bb_rst_i) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_hold_addr <= '0;
      r_vpipe     <= '0;
      r_lpipe     <= '0;
    end else begin
      // Read-valid/last travel alongside the SRAM's own read pipeline.
      r_vpipe[0] <= w_rd_issue;
      r_lpipe[0] <= w_rd_issue && w_issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
        r_lpipe[i] <= r_lpipe[i-1];
      end

      if (sram_ce) begin
        r_hold_addr <= sram_waddr;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we  <= bb.bb_we_i;
            r_sel <= bb.bb_sel_i;
            if (bb.bb_len_i != '0) begin
              r_state <= ST_BURST;
              r_busy  <= 1'b1;
            end else if (!bb.bb_we_i) begin
              r_state <= ST_DRAIN;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_gen_last) begin
            r_state <= r_we ? ST_IDLE : ST_DRAIN;
            r_busy  <= !r_we;
          end
        end
        ST_DRAIN: begin
          // Leave once the final beat is on the bus; busy covers that cycle.
          if (r_lpipe[RD_LAT-1]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sram_din       = bb.bb_din_i;
  assign bb.bb_busy_o   = r_busy;
  assign bb.bb_dout_o   = sram_dout;
  assign bb.bb_rvalid_o = r_vpipe[RD_LAT-1];
  assign bb.bb_rlast_o  = r_lpipe[RD_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_bb2sram_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_bb2sram_burst
// Description : Self-checking bench for bb2sram_burst. An SRAM macro model
//               answers the bridge; a reference model derives every beat's
//               address, timing and read data from the burst rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bb2sram_burst;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int LW      = 4;
  localparam int RD_LAT  = 2;
  localparam int SW      = DW / 8;
  localparam int WORD_AW = AW - 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bb2sram_burst_if #(.DW(DW), .AW(AW), .LW(LW)) u_bus ();

  logic               sram_ce;
  logic               sram_we;
  logic [WORD_AW-1:0] sram_waddr;
  logic [DW-1:0]      sram_din;
  logic [SW-1:0]      sram_sel;
  logic [DW-1:0]      sram_dout;

  bb2sram_burst #(.DW(DW), .AW(AW), .LW(LW), .RD_LAT(RD_LAT)) u_dut (
    .bb_clk_i   (clk),
    .bb_rst_i   (rst),
    .bb         (u_bus),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_waddr (sram_waddr),
    .sram_din   (sram_din),
    .sram_sel   (sram_sel),
    .sram_dout  (sram_dout)
  );

  // ---------------- SRAM macro model (environment) ----------------
  logic [DW-1:0] sram_arr [logic [WORD_AW-1:0]];
  logic [DW-1:0] rd_pipe  [RD_LAT];
  logic [DW-1:0] env_word;

  function automatic logic [DW-1:0] env_rd(input logic [WORD_AW-1:0] a);
    return sram_arr.exists(a) ? sram_arr[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (sram_ce && sram_we) begin
      env_word = env_rd(sram_waddr);
      for (int b = 0; b < SW; b++)
        if (sram_sel[b]) env_word[8*b +: 8] = sram_din[8*b +: 8];
      sram_arr[sram_waddr] = env_word;
    end
    rd_pipe[0] <= (sram_ce && !sram_we) ? env_rd(sram_waddr) : DW'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_dout = rd_pipe[RD_LAT-1];

  // ---------------- reference memory and checking ----------------
  logic [DW-1:0] ref_mem [logic [WORD_AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [WORD_AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int burst_id = 0;
  int cyc_id   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s burst=%0d cyc=%0d got=0x%0h exp=0x%0h",
                  tag, burst_id, cyc_id, got, exp);
  endtask

  // Runs one burst, checking every cycle from accept until the bridge is idle
  // again. abort_at >= 0 asserts reset at that cycle instead of finishing.
  task automatic run_burst(input logic we, input logic [AW-1:0] addr,
                           input logic [SW-1:0] sel, input logic [LW-1:0] len,
                           input logic wrap, input bit poke,
                           input logic [DW-1:0] first_data, input int abort_at);
    logic [WORD_AW-1:0] a [$];
    logic [DW-1:0]      d [$];
    logic [WORD_AW-1:0] w0, mask;
    logic [DW-1:0]      dv, wd;
    int n, last_c, k;
    bit pow2, exp_rv;

    burst_id++;
    n      = int'(len) + 1;
    pow2   = ((n & (n - 1)) == 0);
    mask   = WORD_AW'(n - 1);
    w0     = addr[AW-1:2];
    for (int i = 0; i < n; i++) begin
      if (wrap && pow2) a.push_back((w0 & ~mask) | ((w0 + WORD_AW'(i)) & mask));
      else              a.push_back(w0 + WORD_AW'(i));
      d.push_back(i == 0 ? first_data : DW'($urandom));
    end
    last_c = we ? n : n + RD_LAT;

    for (int c = 0; c <= last_c; c++) begin
      if (c == abort_at) break;
      cyc_id = c;
      if (c == 0) begin
        u_bus.bb_en_i   = 1'b1;
        u_bus.bb_we_i   = we;
        u_bus.bb_addr_i = addr;
        u_bus.bb_sel_i  = sel;
        u_bus.bb_len_i  = len;
        u_bus.bb_wrap_i = wrap;
      end else begin
        // Requests while busy must be ignored; live fields must not leak in.
        u_bus.bb_en_i   = poke && (c < last_c) && ($urandom_range(0, 2) == 0);
        u_bus.bb_we_i   = 1'($urandom);
        u_bus.bb_addr_i = AW'($urandom);
        u_bus.bb_sel_i  = SW'($urandom);
        u_bus.bb_len_i  = LW'($urandom);
        u_bus.bb_wrap_i = 1'($urandom);
      end
      u_bus.bb_din_i = (c < n) ? d[c] : DW'($urandom);
      #1;
      chk("busy", u_bus.bb_busy_o, (c >= 1) && (c < last_c));
      if (c < n) begin
        chk("ce", sram_ce, 1'b1);
        chk("waddr", sram_waddr, a[c]);
        chk("we", sram_we, we);
        chk("sel", sram_sel, we ? sel : {SW{1'b1}});
        if (we) begin
          chk("din", sram_din, d[c]);
          dv = d[c];
          wd = ref_rd(a[c]);
          for (int b = 0; b < SW; b++) if (sel[b]) wd[8*b +: 8] = dv[8*b +: 8];
          ref_mem[a[c]] = wd;
        end
      end else begin
        chk("ce_idle", sram_ce, 1'b0);
        chk("we_idle", sram_we, 1'b0);
        chk("waddr_hold", sram_waddr, a[n-1]);
      end
      k      = c - RD_LAT;
      exp_rv = !we && (k >= 0) && (k < n);
      chk("rvalid", u_bus.bb_rvalid_o, exp_rv);
      chk("rlast", u_bus.bb_rlast_o, exp_rv && (k == n - 1));
      if (exp_rv) chk("rdata", u_bus.bb_dout_o, ref_rd(a[k]));
      @(posedge clk); #1;
    end
    u_bus.bb_en_i = 1'b0;

    if (abort_at >= 0) begin
      cyc_id = abort_at;
      rst = 1'b1;
      #1;
      chk("rst_busy", u_bus.bb_busy_o, 1'b0);
      chk("rst_ce", sram_ce, 1'b0);
      chk("rst_we", sram_we, 1'b0);
      chk("rst_rvalid", u_bus.bb_rvalid_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < RD_LAT + 6; c++) begin
        cyc_id = abort_at + 1 + c;
        chk("post_rst_rvalid", u_bus.bb_rvalid_o, 1'b0);
        chk("post_rst_busy", u_bus.bb_busy_o, 1'b0);
        chk("post_rst_ce", sram_ce, 1'b0);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    u_bus.bb_en_i   = 1'b0;
    u_bus.bb_we_i   = 1'b0;
    u_bus.bb_addr_i = '0;
    u_bus.bb_sel_i  = '0;
    u_bus.bb_len_i  = '0;
    u_bus.bb_wrap_i = 1'b0;
    u_bus.bb_din_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", u_bus.bb_busy_o, 1'b0);
    chk("reset_rvalid", u_bus.bb_rvalid_o, 1'b0);
    chk("reset_rlast", u_bus.bb_rlast_o, 1'b0);
    chk("reset_ce", sram_ce, 1'b0);
    chk("reset_we", sram_we, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write, then read it back (only the two enabled lanes change).
    run_burst(1'b1, 32'h0000_0100, 4'b0011, 4'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, -1);
    run_burst(1'b0, 32'h0000_0100, 4'b1111, 4'd0, 1'b0, 1'b0, '0, -1);
    // Linear read of four beats.
    run_burst(1'b0, 32'h0000_0200, 4'b1111, 4'd3, 1'b0, 1'b1, '0, -1);
    // Wrap read, power-of-two and non-power-of-two block sizes.
    run_burst(1'b0, 32'h0000_0218, 4'b1111, 4'd3, 1'b1, 1'b0, '0, -1);
    run_burst(1'b0, 32'h0000_0218, 4'b1111, 4'd2, 1'b1, 1'b0, '0, -1);
    // Linear write across the top of the word space, with ignored requests.
    run_burst(1'b1, 32'hFFFF_FFFC, 4'b1111, 4'd1, 1'b0, 1'b1, 32'h1234_5678, -1);
    run_burst(1'b0, 32'hFFFF_FFFC, 4'b1111, 4'd1, 1'b0, 1'b1, '0, -1);
    // Full-length wrap write and read.
    run_burst(1'b1, 32'h0000_0044, 4'b1111, 4'd15, 1'b1, 1'b1, 32'hA5A5_5A5A, -1);
    run_burst(1'b0, 32'h0000_0044, 4'b1111, 4'd15, 1'b1, 1'b1, '0, -1);

    // Randomized bursts over a small window plus the top of the word space.
    repeat (60) begin
      logic [AW-1:0] ra;
      if ($urandom_range(0, 5) == 0)
        ra = {WORD_AW'(30'h3FFF_FFF0 + 30'($urandom_range(0, 15))), 2'($urandom)};
      else
        ra = {WORD_AW'($urandom_range(0, 63)), 2'($urandom)};
      run_burst(1'($urandom), ra, SW'($urandom), LW'($urandom), 1'($urandom),
                1'b1, DW'($urandom), -1);
    end

    // Reset in the middle of a long read, then normal operation again.
    run_burst(1'b0, 32'h0000_0300, 4'b1111, 4'd7, 1'b0, 1'b0, '0, 3);
    run_burst(1'b1, 32'h0000_0300, 4'b1100, 4'd2, 1'b0, 1'b1, 32'hCAFE_F00D, -1);
    run_burst(1'b0, 32'h0000_0300, 4'b1111, 4'd3, 1'b1, 1'b1, '0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
